// File: rtl/dii_package.sv
// Debug interconnect (DII) flit type shared by all ring participants.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/osd_reg_pkg.sv
// Register-access protocol constants: packet type, request/response subtypes, response lengths.
package osd_reg_pkg;

    localparam logic [1:0] RegType = 2'b00;

    localparam logic [3:0] SubReqRead   = 4'b0000;
    localparam logic [3:0] SubReqWrite  = 4'b0100;
    localparam logic [3:0] SubRespRdOk  = 4'b1000;
    localparam logic [3:0] SubRespRdErr = 4'b1100;
    localparam logic [3:0] SubRespWrOk  = 4'b1110;
    localparam logic [3:0] SubRespWrErr = 4'b1111;

    localparam int unsigned RespLenShort = 3;
    localparam int unsigned RespLenRead  = 4;

    function automatic logic [15:0] req_header(input logic write);
        return {RegType, (write ? SubReqWrite : SubReqRead), 10'h0};
    endfunction

    // A response subtype is acceptable only if it answers the outstanding operation.
    function automatic logic resp_sub_ok(input logic write, input logic [3:0] sub);
        if (write) begin
            return (sub == SubRespWrOk) || (sub == SubRespWrErr);
        end
        return (sub == SubRespRdOk) || (sub == SubRespRdErr);
    endfunction

endpackage

// File: rtl/osd_reg_initiator_rx.sv
// Response parser: tracks packet boundaries on the incoming stream and strobes done/err/rdata
// when a well-formed response to the outstanding request ends.
module osd_reg_initiator_rx
    import dii_package::*;
    import osd_reg_pkg::*;
#(
    parameter int unsigned MAX_PKT_LEN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  dii_flit     flit_in,
    input  logic        active,
    input  logic [15:0] exp_src,
    input  logic [15:0] exp_dest,
    input  logic        op_write,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata
);

    localparam int unsigned CntW = $clog2(MAX_PKT_LEN + 2);
    localparam logic [CntW-1:0] CntSat    = CntW'(MAX_PKT_LEN + 1);
    localparam logic [CntW-1:0] CntMaxIdx = CntW'(MAX_PKT_LEN);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            bad_q, bad_d;
    logic [3:0]      sub_q, sub_d;
    logic [3:0]      sub_cur;
    logic            bad_word;
    logic            bad_all;
    logic            bad_len;

    always_comb begin
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        sub_d   = sub_q;
        done    = 1'b0;
        err     = 1'b0;
        rdata   = '0;
        sub_cur = (cnt_q == CntW'(2)) ? flit_in.data[13:10] : sub_q;

        // Any word seen while not waiting poisons the rest of its packet.
        bad_word = !active || (cnt_q >= CntMaxIdx);
        if (cnt_q == '0) begin
            bad_word = bad_word || (flit_in.data != exp_src);
        end else if (cnt_q == CntW'(1)) begin
            bad_word = bad_word || (flit_in.data != exp_dest);
        end else if (cnt_q == CntW'(2)) begin
            bad_word = bad_word || (flit_in.data[15:14] != RegType)
                       || !resp_sub_ok(op_write, flit_in.data[13:10]);
        end
        bad_all = bad_q || bad_word;

        if (cnt_q < CntW'(2)) begin
            bad_len = 1'b1;
        end else if (sub_cur == SubRespRdOk) begin
            bad_len = (cnt_q != CntW'(RespLenRead - 1));
        end else begin
            bad_len = (cnt_q != CntW'(RespLenShort - 1));
        end

        if (flit_in.valid) begin
            if (flit_in.last) begin
                done  = !(bad_all || bad_len);
                err   = done && ((sub_cur == SubRespRdErr) || (sub_cur == SubRespWrErr));
                rdata = (done && (sub_cur == SubRespRdOk)) ? flit_in.data : '0;
                cnt_d = '0;
                bad_d = 1'b0;
                sub_d = '0;
            end else begin
                cnt_d = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
                bad_d = bad_all;
                if (cnt_q == CntW'(2)) begin
                    sub_d = flit_in.data[13:10];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            bad_q <= 1'b0;
            sub_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            bad_q <= bad_d;
            sub_q <= sub_d;
        end
    end

endmodule

// File: rtl/osd_reg_initiator.sv
// DII register-access initiator: one outstanding read/write, registered request flits.
// Optional response timeout enabled by defining OSD_REGINIT_TIMEOUT_EN.
module osd_reg_initiator
    import dii_package::*;
    import osd_reg_pkg::*;
#(
    parameter int unsigned MAX_PKT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] id,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_dest,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic        resp_timeout,
    output logic [15:0] resp_rdata,
    output dii_flit     debug_out,
    input  logic        debug_out_ready,
    input  dii_flit     debug_in,
    output logic        debug_in_ready
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StTxDest = 3'd1;
    localparam logic [2:0] StTxSrc  = 3'd2;
    localparam logic [2:0] StTxHdr  = 3'd3;
    localparam logic [2:0] StTxAddr = 3'd4;
    localparam logic [2:0] StTxData = 3'd5;
    localparam logic [2:0] StWait   = 3'd6;

    logic [2:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [15:0] dest_q, dest_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    dii_flit     out_q, out_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic        resp_timeout_q, resp_timeout_d;
    logic [15:0] resp_rdata_q, resp_rdata_d;

    logic        xfer;
    logic        rx_done;
    logic        rx_err;
    logic [15:0] rx_rdata;
    logic        tmo_fire;

    osd_reg_initiator_rx #(
        .MAX_PKT_LEN (MAX_PKT_LEN)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .flit_in  (debug_in),
        .active   (state_q == StWait),
        .exp_src  (id),
        .exp_dest (dest_q),
        .op_write (write_q),
        .done     (rx_done),
        .err      (rx_err),
        .rdata    (rx_rdata)
    );

`ifdef OSD_REGINIT_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    logic [TmoW-1:0] tmo_q, tmo_d;

    assign tmo_fire = (state_q == StWait) && (tmo_q == TmoLast);

    always_comb begin
        tmo_d = tmo_q;
        if (state_q != StWait) begin
            tmo_d = '0;
        end else if (tmo_q != TmoLast) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_fire   = 1'b0;
`endif

    assign xfer = out_q.valid && debug_out_ready;

    always_comb begin
        state_d        = state_q;
        write_d        = write_q;
        dest_d         = dest_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        out_d          = out_q;
        resp_valid_d   = 1'b0;
        resp_err_d     = 1'b0;
        resp_timeout_d = 1'b0;
        resp_rdata_d   = '0;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d    = req_write;
                    dest_d     = req_dest;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    out_d.valid = 1'b1;
                    out_d.last  = 1'b0;
                    out_d.data  = req_dest;
                    state_d    = StTxDest;
                end
            end
            StTxDest: begin
                if (xfer) begin
                    out_d.data = id;
                    state_d    = StTxSrc;
                end
            end
            StTxSrc: begin
                if (xfer) begin
                    out_d.data = req_header(write_q);
                    state_d    = StTxHdr;
                end
            end
            StTxHdr: begin
                if (xfer) begin
                    out_d.data = addr_q;
                    out_d.last = !write_q;
                    state_d    = StTxAddr;
                end
            end
            StTxAddr: begin
                if (xfer) begin
                    if (write_q) begin
                        out_d.data = wdata_q;
                        out_d.last = 1'b1;
                        state_d    = StTxData;
                    end else begin
                        out_d   = '0;
                        state_d = StWait;
                    end
                end
            end
            StTxData: begin
                if (xfer) begin
                    out_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // A response completing in the timeout cycle takes priority.
                if (rx_done) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = rx_err;
                    resp_rdata_d = rx_rdata;
                    state_d      = StIdle;
                end else if (tmo_fire) begin
                    resp_valid_d   = 1'b1;
                    resp_err_d     = 1'b1;
                    resp_timeout_d = 1'b1;
                    state_d        = StIdle;
                end
            end
            default: begin
                out_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            write_q        <= 1'b0;
            dest_q         <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            out_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_rdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            write_q        <= write_d;
            dest_q         <= dest_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            out_q          <= out_d;
            resp_valid_q   <= resp_valid_d;
            resp_err_q     <= resp_err_d;
            resp_timeout_q <= resp_timeout_d;
            resp_rdata_q   <= resp_rdata_d;
        end
    end

    assign req_ready      = rst_n && (state_q == StIdle);
    assign debug_out      = out_q;
    assign debug_in_ready = 1'b1;
    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_timeout   = resp_timeout_q;
    assign resp_rdata     = resp_rdata_q;

endmodule
